// File: rtl/store_buffer_pkg.sv
// Shared widths and types for the in-order store buffer.
// Pointers carry one extra wrap bit above the entry index.
package store_buffer_pkg;

  localparam int RV32_ADDR_WIDTH = 32;
  localparam int RV32_DATA_WIDTH = 32;
  localparam int STBUF_DEPTH     = 8;
  localparam int STBUF_ENT_SEL   = 3;

  typedef struct packed {
    logic [RV32_ADDR_WIDTH-1:0] addr;
    logic [RV32_DATA_WIDTH-1:0] data;
  } stbuf_ent_t;

endpackage

// File: rtl/store_buffer_fwd_sel.sv
// Age-ordered priority picker: youngest set match bit in [head, tail).
// Walks oldest to youngest so the last hit found wins.
module stbuf_fwd_sel #(
  parameter int DEPTH   = 8,
  parameter int ENT_SEL = 3
) (
  input  logic [DEPTH-1:0]   i_match,
  input  logic [ENT_SEL:0]   i_head,
  input  logic [ENT_SEL:0]   i_tail,
  output logic               o_hit,
  output logic [ENT_SEL-1:0] o_sel
);

  logic [ENT_SEL:0]   cnt;
  logic [ENT_SEL-1:0] idx;

  always_comb begin
    cnt   = i_tail - i_head;
    o_hit = 1'b0;
    o_sel = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = i_head[ENT_SEL-1:0] + ENT_SEL'(k);
      if ((ENT_SEL+1)'(k) < cnt && i_match[idx]) begin
        o_hit = 1'b1;
        o_sel = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: holds executed stores until commit, drains
// committed stores to dmem and forwards the youngest match to loads.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_exfin_st,
  input  logic [RV32_ADDR_WIDTH-1:0] i_exfin_st_addr,
  input  logic [RV32_DATA_WIDTH-1:0] i_exfin_st_data,
  output logic                       o_stbuf_full,
  input  logic [1:0]                 i_com_st_num,
  input  logic                       i_flush,
  input  logic [RV32_ADDR_WIDTH-1:0] i_ld_addr,
  output logic                       o_stbuf_addr_hit,
  output logic [RV32_DATA_WIDTH-1:0] o_stbuf_rd_data,
  input  logic                       i_dmem_occupy,
  output logic                       o_dmem_we,
  output logic [RV32_ADDR_WIDTH-1:0] o_dmem_wr_addr,
  output logic [RV32_DATA_WIDTH-1:0] o_dmem_wr_data,
  output logic                       o_stbuf_empty
);

  localparam int SEL = STBUF_ENT_SEL;

  typedef logic [SEL:0] ptr_t;

  stbuf_ent_t mem_q [STBUF_DEPTH];

  ptr_t head_q, head_d;
  ptr_t com_q, com_d;
  ptr_t tail_q, tail_d;
  ptr_t unc, com_add;

  logic                   push;
  logic                   drain;
  logic [STBUF_DEPTH-1:0] match;
  logic                   hit;
  logic [SEL-1:0]         sel;

  assign o_stbuf_full  = (head_q[SEL-1:0] == tail_q[SEL-1:0])
                       && (head_q[SEL] != tail_q[SEL]);
  assign o_stbuf_empty = (head_q == tail_q);

  assign push  = i_exfin_st && !o_stbuf_full && !i_flush;
  assign drain = (head_q != com_q) && !i_dmem_occupy;

  assign o_dmem_we      = drain;
  assign o_dmem_wr_addr = mem_q[head_q[SEL-1:0]].addr;
  assign o_dmem_wr_data = mem_q[head_q[SEL-1:0]].data;

  // Over-commit is clamped to what is actually uncommitted.
  always_comb begin
    unc     = tail_q - com_q;
    com_add = ptr_t'(i_com_st_num);
    if (com_add > unc) com_add = unc;
    com_d  = com_q + com_add;
    head_d = head_q + ptr_t'(drain);
    tail_d = i_flush ? com_d : tail_q + ptr_t'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      com_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      com_q  <= com_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q[SEL-1:0]].addr <= i_exfin_st_addr;
      mem_q[tail_q[SEL-1:0]].data <= i_exfin_st_data;
    end
  end

  always_comb begin
    for (int i = 0; i < STBUF_DEPTH; i++) begin
      match[i] = (mem_q[i].addr == i_ld_addr);
    end
  end

  stbuf_fwd_sel #(
    .DEPTH   (STBUF_DEPTH),
    .ENT_SEL (SEL)
  ) u_fwd_sel (
    .i_match (match),
    .i_head  (head_q),
    .i_tail  (tail_q),
    .o_hit   (hit),
    .o_sel   (sel)
  );

  assign o_stbuf_addr_hit = hit;
  assign o_stbuf_rd_data  = hit ? mem_q[sel].data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random stimulus against a queue-based store buffer model.
// Stores live in a FIFO queue; ncom counts committed entries at its front.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        full;
  logic [1:0]  com_num = '0;
  logic        flush = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        hit;
  logic [31:0] rd_data;
  logic        occ = 1'b0;
  logic        we;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        empty;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_exfin_st       (st),
    .i_exfin_st_addr  (st_addr),
    .i_exfin_st_data  (st_data),
    .o_stbuf_full     (full),
    .i_com_st_num     (com_num),
    .i_flush          (flush),
    .i_ld_addr        (ld_addr),
    .o_stbuf_addr_hit (hit),
    .o_stbuf_rd_data  (rd_data),
    .i_dmem_occupy    (occ),
    .o_dmem_we        (we),
    .o_dmem_wr_addr   (wr_addr),
    .o_dmem_wr_data   (wr_data),
    .o_stbuf_empty    (empty)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   ncom = 0;
  int   vecs = 0;
  int   errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    logic        e_hit;
    logic [31:0] e_rd;
    logic        e_we;
    e_hit = 1'b0;
    e_rd  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == ld_addr) begin
        e_hit = 1'b1;
        e_rd  = q[i].d;
        break;
      end
    end
    e_we = (ncom > 0) && !occ;
    chk("full", 32'(full), 32'(q.size() == STBUF_DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("hit", 32'(hit), 32'(e_hit));
    chk("rd_data", rd_data, e_rd);
    chk("dmem_we", 32'(we), 32'(e_we));
    if (e_we) begin
      chk("wr_addr", wr_addr, q[0].a);
      chk("wr_data", wr_data, q[0].d);
    end
  endtask

  task automatic step(input logic s, input logic [31:0] a,
                      input logic [31:0] d, input int n,
                      input logic fl, input logic [31:0] ld,
                      input logic oc);
    bit f_pre;
    bit dr;
    int add;
    @(negedge clk);
    st = s; st_addr = a; st_data = d;
    com_num = 2'(n); flush = fl; ld_addr = ld; occ = oc;
    #1;
    chk_outputs();
    f_pre = (q.size() == STBUF_DEPTH);
    dr    = (ncom > 0) && !oc;
    add   = n;
    if (add > q.size() - ncom) add = q.size() - ncom;
    @(posedge clk);
    ncom += add;
    if (fl) begin
      while (q.size() > ncom) void'(q.pop_back());
    end else if (s && !f_pre) begin
      q.push_back('{a: a, d: d});
    end
    if (dr) begin
      void'(q.pop_front());
      ncom--;
    end
  endtask

  task automatic idle(input logic [31:0] ld);
    step(1'b0, '0, '0, 0, 1'b0, ld, 1'b0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic commit_all_and_drain();
    int n;
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      n = q.size() - ncom;
      if (n > 2) n = 2;
      step(1'b0, '0, '0, n, 1'b0, 32'h300, 1'b0);
    end
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  logic [31:0] addrs [5];

  initial begin
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;
    addrs[3] = 32'h10c; addrs[4] = 32'h110;

    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single store, commit, drain
    push(32'h100, 32'hAA);
    step(1'b0, '0, '0, 1, 1'b0, 32'h100, 1'b0);
    idle(32'h100);
    idle(32'h100);

    // youngest-match forwarding on uncommitted entries
    push(32'h200, 32'h11);
    push(32'h200, 32'h22);
    idle(32'h200);
    idle(32'h204);
    step(1'b0, '0, '0, 0, 1'b1, 32'h200, 1'b0);
    idle(32'h200);

    // fill, overflow drop, drain frees space, wrap
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(4 * (i % 2)), 32'(i + 1));
    push(32'h300, 32'hDEAD);
    step(1'b0, '0, '0, 2, 1'b0, 32'h300, 1'b0);
    idle(32'h300);
    idle(32'h300);
    push(32'h300, 32'h55);
    push(32'h300, 32'h66);
    idle(32'h300);
    idle(32'h304);
    commit_all_and_drain();

    // commit with flush in the same cycle
    push(32'hA0, 32'h1);
    push(32'hB0, 32'h2);
    push(32'hC0, 32'h3);
    step(1'b1, 32'hD0, 32'h4, 1, 1'b1, 32'hB0, 1'b0);
    idle(32'hB0);
    idle(32'hB0);

    // memory port held by loads
    push(32'hE0, 32'h5);
    push(32'hE4, 32'h6);
    step(1'b0, '0, '0, 2, 1'b0, 32'hE0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 0, 1'b0, 32'hE0, 1'b1);
    idle(32'hE4);
    idle(32'hE4);
    idle(32'hE4);

    // asynchronous reset mid-drain
    push(32'hF0, 32'h7);
    push(32'hF4, 32'h8);
    push(32'hF8, 32'h9);
    step(1'b0, '0, '0, 2, 1'b0, 32'hF0, 1'b0);
    #2;
    chk("pre_rst_we", 32'(we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", 32'(we), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    q.delete();
    ncom = 0;
    @(posedge clk);
    #1;
    chk("rst_hold_we", 32'(we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(32'hF0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      int unc;
      int n;
      unc = q.size() - ncom;
      n = $urandom_range(0, 2);
      if (n > unc) n = unc;
      step(1'($urandom_range(0, 99) < 60),
           addrs[$urandom_range(0, 3)],
           $urandom,
           n,
           1'($urandom_range(0, 99) < 4),
           addrs[$urandom_range(0, 4)],
           1'($urandom_range(0, 99) < 30));
    end
    commit_all_and_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order circular store buffer at the far end of the load/store unit's store path.
- Accepts executed stores (address + data), holds them until the reorder buffer commits them, then drains committed stores to data memory in cycles when loads do not occupy the memory port.
- Also supplies store-to-load forwarding for the load unit's address lookup.
- Sits between the load/store unit, the commit stage and the data-memory write port.

Parameters:
- STBUF_DEPTH, 8, number of entries; power of two, at least 2.
- STBUF_ENT_SEL, 3, log2(STBUF_DEPTH); entry index width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_exfin_st  input  1  store push valid from load/store unit
- i_exfin_st_addr  input  `RV32_ADDR_WIDTH  store address
- i_exfin_st_data  input  `RV32_DATA_WIDTH  store data (full word)
- o_stbuf_full  output  1  buffer full; pusher must not push
- i_com_st_num  input  2  number of stores committed this cycle (0, 1 or 2)
- i_flush  input  1  mispredict flush; discard all uncommitted entries
- i_ld_addr  input  `RV32_ADDR_WIDTH  load lookup address
- o_stbuf_addr_hit  output  1  a valid entry matches i_ld_addr
- o_stbuf_rd_data  output  `RV32_DATA_WIDTH  data of the youngest matching entry
- i_dmem_occupy  input  1  load owns the memory port this cycle
- o_dmem_we  output  1  drain write enable
- o_dmem_wr_addr  output  `RV32_ADDR_WIDTH  drain address
- o_dmem_wr_data  output  `RV32_DATA_WIDTH  drain data
- o_stbuf_empty  output  1  no valid entries

Behaviour:
- State:
  - Per-entry addr and data arrays.
  - Three pointers of STBUF_ENT_SEL+1 bits (extra wrap bit): head (oldest), com (first uncommitted), tail (next free).
  - Valid region is [head, tail); committed region is [head, com).
- Reset (async, rst_n low): all pointers 0; arrays need not be cleared.
  - Outputs during reset: o_stbuf_full=0, o_stbuf_empty=1, o_dmem_we=0, o_stbuf_addr_hit=0, o_stbuf_rd_data=0.
  - Reset mid-drain aborts the drain with no write.
- Full/empty:
  - o_stbuf_full = index bits equal and wrap bits differ (head vs tail).
  - o_stbuf_empty = head==tail.
  - Both are combinational from registered pointers only.
- Push:
  - If i_exfin_st && !o_stbuf_full && !i_flush: write entry[tail], tail+1 at the clock edge.
  - A push while full is dropped (bench assertion).
  - A drain in the same cycle does not free space for a push in that cycle.
- Commit:
  - com += i_com_st_num.
  - i_com_st_num greater than the uncommitted count (tail−com) is illegal (assertion); the design saturates com at tail.
- Drain (combinational request, one store per cycle):
  - o_dmem_we = (head!=com) && !i_dmem_occupy.
  - o_dmem_wr_addr/data = entry[head].
  - Memory write occurs at the edge; head+1 at the same edge.
  - Drain blocked by i_dmem_occupy retries the next cycle with unchanged outputs.
  - A store committed in cycle t is drainable no earlier than t+1.
- Flush:
  - tail <= com after that cycle's commit is applied, i.e. tail <= com + i_com_st_num.
  - A push in the same cycle is discarded.
  - Committed entries survive, and drain proceeds normally during flush.
- Forwarding (combinational):
  - Compare i_ld_addr against all entries in [head, tail), both committed and uncommitted; full-word address match.
  - Select the youngest match (closest to tail).
  - o_stbuf_rd_data = 0 when there is no hit.
  - An entry being drained this cycle still forwards.
  - A same-cycle push is not visible to the lookup.
- Wrap-around: pointers roll from STBUF_DEPTH−1 to 0, toggling the wrap bit. Youngest-first priority must be correct across the wrap.

Decomposition:
- Constants STBUF_DEPTH and STBUF_ENT_SEL go in constants.vh, alongside the existing RV32 width and RRF constants.
- One natural sub-module: stbuf_fwd_sel, the age-ordered youngest-match priority selector. Inputs: per-entry match vector, head and tail. Outputs: hit and selected index.

Test Plan:
- Reset, push 0x100/0xAA, then commit 1 with i_dmem_occupy=0 → o_dmem_we=1 with 0x100/0xAA the cycle after commit; afterwards o_stbuf_empty=1.
- Push 0x200/0x11, then 0x200/0x22, uncommitted; lookup 0x200 → hit=1, data 0x22. Lookup 0x204 → hit=0, data 0.
- Fill 8 entries → o_stbuf_full=1 and a 9th push is dropped. Commit 2 and drain 1 → full deasserts the cycle after the drain. Refill to exercise wrap; forwarding returns the post-wrap youngest value.
- Push A, B, C; commit 1 (A) together with i_flush in the same cycle → B and C discarded, A drains. Afterwards a lookup of B's address misses.
- Commit 2 with i_dmem_occupy held high for 3 cycles → o_dmem_we=0 for 3 cycles, then two consecutive drains in order.
- Assert rst_n low asynchronously mid-cycle while 3 entries are valid → o_dmem_we falls immediately, o_stbuf_empty=1, and no write occurs.
